wb_block_master: RTL and testbench

Command-driven Wishbone classic initiator that drives the secure-memory SRAM Wishbone responder. It fills a block of words with an incrementing pattern, or reads a block back and returns a 32-bit running sum. It sits between on-chip control logic (self-test / scrub sequencer) and the SRAM Wishbone port, and performs one single transfer at a time.

---
 rtl/wb_block_master.sv | 161 ++++++++++++++++
 tb/tb_wb_block_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_block_master.sv
// wb_block_master: Wishbone classic initiator that fills a block of SRAM words
// with an incrementing pattern (FILL) or reads a block back and returns a
// 32-bit running sum (READSUM). One single transfer is outstanding at a time.
module wb_block_master #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                   wb_clk_i,
    input  logic                   rst_n,
    // command side
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_op_i,
    input  logic [ADDR_WD-1:0]     cmd_addr_i,
    input  logic [ADDR_WD-1:0]     cmd_len_i,
    input  logic [DATA_WD-1:0]     cmd_seed_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [DATA_WD-1:0]     sum_o,
    // Wishbone initiator side
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    output logic                   wb_we_o,
    output logic [ADDR_WD-1:0]     wb_adr_o,
    output logic [DATA_WD-1:0]     wb_dat_o,
    output logic [DATA_WD/8-1:0]   wb_sel_o,
    input  logic [DATA_WD-1:0]     wb_dat_i,
    input  logic                   wb_ack_i
);

    localparam int         SEL_WD   = DATA_WD / 8;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_op;      // 0 = FILL, 1 = READSUM
    logic [ADDR_WD-1:0]   r_addr;
    logic [ADDR_WD-1:0]   r_len;
    logic [ADDR_WD-1:0]   r_idx;
    logic [DATA_WD-1:0]   r_seed;
    logic [7:0]           r_tmo;
    logic                 r_err;
    logic [DATA_WD-1:0]   r_sum;

    logic                 w_issue;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_timeout;
    logic                 w_last;
    logic [ADDR_WD-1:0]   w_idx_nxt;

    assign w_issue   = (r_state == S_ISSUE);
    assign w_idx_nxt = r_idx + 1'b1;
    assign w_last    = (w_idx_nxt == r_len);

    // State register; reset returns to IDLE immediately, even mid-transfer.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values,
            // which is what the hardware does; blocking here creates order races.
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the one-cycle strobes that steer the datapath.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a
        // variable unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cmd_len_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An ack in the timeout cycle still completes the transfer.
                if (wb_ack_i) begin
                    w_xfer = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command latch, address/index advance, timeout counter, sum and error.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= 1'b0;
            r_addr <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_seed <= '0;
            r_tmo  <= '0;
            r_err  <= 1'b0;
            r_sum  <= '0;
        end else if (w_accept) begin
            r_op   <= cmd_op_i;
            r_addr <= cmd_addr_i;
            r_len  <= cmd_len_i;
            r_seed <= cmd_seed_i;
            r_idx  <= '0;
            r_tmo  <= '0;
            r_err  <= 1'b0;
            r_sum  <= '0;
        end else if (w_xfer) begin
            if (r_op) begin
                r_sum <= r_sum + wb_dat_i;
            end
            r_addr <= r_addr + 1'b1;
            r_idx  <= w_idx_nxt;
            r_tmo  <= '0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else if (w_issue) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    // Bus outputs are gated by ISSUE so they are all zero outside a transfer.
    assign wb_cyc_o    = w_issue;
    assign wb_stb_o    = w_issue;
    assign wb_we_o     = w_issue & ~r_op;
    assign wb_adr_o    = w_issue ? r_addr : '0;
    assign wb_dat_o    = (w_issue && !r_op) ?
                         (r_seed + {{(DATA_WD-ADDR_WD){1'b0}}, r_idx}) : '0;
    assign wb_sel_o    = {SEL_WD{w_issue}};

    assign cmd_ready_o = (r_state == S_IDLE);
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign err_o       = r_err;
    assign sum_o       = r_sum;

endmodule

// File: tb/tb_wb_block_master.sv
// Bench for wb_block_master: behavioural SRAM responder with registered ack,
// a queue of expected bus transfers, and directed command steps.
module tb_wb_block_master;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int TMO = 15;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } xfer_t;

    logic            wb_clk_i;
    logic            rst_n;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_op_i;
    logic [AW-1:0]   cmd_addr_i;
    logic [AW-1:0]   cmd_len_i;
    logic [DW-1:0]   cmd_seed_i;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic [DW-1:0]   sum_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;

    int              checks = 0;
    int              errors = 0;
    xfer_t           exp_q[$];
    int              stb_total = 0;
    logic [AW-1:0]   last_adr = '0;
    logic            no_ack = 1'b0;
    logic [DW-1:0]   mem [0:(1<<AW)-1];

    wb_block_master #(
        .ADDR_WD (AW),
        .DATA_WD (DW),
        .TIMEOUT (TMO)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .rst_n       (rst_n),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_seed_i  (cmd_seed_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .sum_o       (sum_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM responder: registered ack, one ack per two stb cycles, no_ack mutes it.
    always @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_i <= 1'b0;
            wb_dat_i <= '0;
        end else begin
            wb_ack_i <= wb_cyc_o && wb_stb_o && !wb_ack_i && !no_ack;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !no_ack) begin
                if (wb_we_o) mem[wb_adr_o] <= wb_dat_o;
                wb_dat_i <= mem[wb_adr_o];
            end
        end
    end

    // Monitor: counts stb cycles and compares each completed transfer to the queue.
    always @(negedge wb_clk_i) begin : mon
        xfer_t e;
        if (rst_n) begin
            if (wb_stb_o) begin
                stb_total <= stb_total + 1;
                last_adr  <= wb_adr_o;
            end
            if (wb_cyc_o || wb_stb_o) check("cyc_eq_stb", wb_cyc_o, wb_stb_o);
            if (wb_stb_o && wb_ack_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_we", wb_we_o, e.we);
                    check("xfer_adr", wb_adr_o, e.adr);
                    check("xfer_sel", wb_sel_o, 4'hF);
                    if (e.we) check("xfer_dat", wb_dat_o, e.dat);
                end
            end
        end
    end

    int stb_base;

    task automatic start_cmd(input logic op, input logic [AW-1:0] addr,
                             input logic [AW-1:0] len, input logic [DW-1:0] seed);
        @(negedge wb_clk_i);
        check("ready_before_cmd", cmd_ready_o, 1);
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_seed_i  = seed;
        cmd_valid_i = 1'b1;
        stb_base    = stb_total;
        @(posedge wb_clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    // Latency counts negedges after the accept edge until done_o is seen.
    task automatic wait_done(output int lat, output int stb_n);
        lat = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge wb_clk_i);
            if (done_o) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
        stb_n = stb_total - stb_base;
        check("cyc_low_at_done", wb_cyc_o, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic push_block(input logic we, input logic [AW-1:0] addr,
                              input int len, input logic [DW-1:0] seed);
        for (int i = 0; i < len; i++) begin
            xfer_t x;
            x.we  = we;
            x.adr = addr + AW'(i);
            x.dat = seed + DW'(i);
            exp_q.push_back(x);
        end
    endtask

    initial begin
        int lat;
        int stb_n;
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 1'b0;
        cmd_addr_i  = '0;
        cmd_len_i   = '0;
        cmd_seed_i  = '0;
        repeat (2) @(negedge wb_clk_i);
        check("rst_ready", cmd_ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_sel", wb_sel_o, 0);
        rst_n = 1'b1;
        @(negedge wb_clk_i);

        // FILL 0x010, len 4
        push_block(1'b1, 9'h010, 4, 32'hA5A5_0000);
        start_cmd(1'b0, 9'h010, 9'd4, 32'hA5A5_0000);
        wait_done(lat, stb_n);
        check("fill_latency", lat, 9);
        check("fill_stb_cycles", stb_n, 8);
        check("fill_err", err_o, 0);
        @(negedge wb_clk_i);
        check("fill_done_pulse", done_o, 0);
        check("fill_ready_after", cmd_ready_o, 1);

        // READSUM of the same block
        push_block(1'b0, 9'h010, 4, 32'h0);
        start_cmd(1'b1, 9'h010, 9'd4, 32'h0);
        wait_done(lat, stb_n);
        check("rsum_latency", lat, 9);
        check("rsum_sum", sum_o, 32'h9694_0006);
        check("rsum_err", err_o, 0);

        // FILL across the address wrap, then read back word 0x000
        push_block(1'b1, 9'h1FE, 3, 32'h1234_0000);
        start_cmd(1'b0, 9'h1FE, 9'd3, 32'h1234_0000);
        wait_done(lat, stb_n);
        check("wrap_latency", lat, 7);
        push_block(1'b0, 9'h000, 1, 32'h0);
        start_cmd(1'b1, 9'h000, 9'd1, 32'h0);
        wait_done(lat, stb_n);
        check("wrap_sum", sum_o, 32'h1234_0002);

        // Non-acking responder: timeout after exactly TMO stb cycles
        no_ack = 1'b1;
        start_cmd(1'b0, 9'h050, 9'd2, 32'h0);
        wait_done(lat, stb_n);
        check("tmo_latency", lat, TMO + 1);
        check("tmo_stb_cycles", stb_n, TMO);
        check("tmo_adr_held", last_adr, 9'h050);
        check("tmo_err", err_o, 1);
        @(negedge wb_clk_i);
        check("tmo_done_pulse", done_o, 0);
        check("tmo_err_held", err_o, 1);
        no_ack = 1'b0;

        // len 0: immediate done, no bus traffic, clears err and sum
        start_cmd(1'b1, 9'h000, 9'd0, 32'h0);
        wait_done(lat, stb_n);
        check("len0_latency", lat, 1);
        check("len0_stb_cycles", stb_n, 0);
        check("len0_err_cleared", err_o, 0);
        check("len0_sum", sum_o, 0);

        // cmd_valid pulse while busy must be ignored
        push_block(1'b1, 9'h020, 2, 32'h0000_0005);
        start_cmd(1'b0, 9'h020, 9'd2, 32'h0000_0005);
        @(negedge wb_clk_i);
        check("busy_during_cmd", busy_o, 1);
        cmd_op_i    = 1'b1;
        cmd_addr_i  = 9'h100;
        cmd_len_i   = 9'd1;
        cmd_valid_i = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        wait_done(lat, stb_n);
        check("busy_ign_latency", lat + 2, 5);
        repeat (4) @(negedge wb_clk_i);
        check("busy_ign_idle", busy_o, 0);
        check("busy_ign_no_extra", stb_total - stb_base, 4);

        // Reset in the middle of a READSUM
        push_block(1'b0, 9'h010, 4, 32'h0);
        start_cmd(1'b1, 9'h010, 9'd4, 32'h0);
        repeat (3) @(negedge wb_clk_i);
        check("mid_partial_sum", sum_o, 32'hA5A5_0000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cyc", wb_cyc_o, 0);
        check("mid_rst_stb", wb_stb_o, 0);
        check("mid_rst_sum", sum_o, 0);
        check("mid_rst_ready", cmd_ready_o, 1);
        exp_q.delete();
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        @(negedge wb_clk_i);
        check("post_rst_ready", cmd_ready_o, 1);
        push_block(1'b0, 9'h010, 4, 32'h0);
        start_cmd(1'b1, 9'h010, 9'd4, 32'h0);
        wait_done(lat, stb_n);
        check("post_rst_latency", lat, 9);
        check("post_rst_sum", sum_o, 32'h9694_0006);

        repeat (2) @(negedge wb_clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
